// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface instr_fetch_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: request, hold for decoder, branch redirect, HALT.
// Optional macro IFETCH_FETCH_CNT_EN adds a saturating consumed-instruction counter (fetch_count).
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_fetch_if.master    imem,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic [15:0]      instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  instr_pc,
  output logic             halted
`ifdef IFETCH_FETCH_CNT_EN
  ,
  output logic [15:0]      fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n;
  logic [15:0]     instr_n;
  logic            instr_valid_n;
  logic [PC_W-1:0] instr_pc_n;

  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = fetch_pc;
  assign halted         = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      instr       <= instr_n;
      instr_valid <= instr_valid_n;
      instr_pc    <= instr_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    instr_n       = instr;
    instr_valid_n = instr_valid;
    instr_pc_n    = instr_pc;

    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          instr_n       = imem.imem_rdata;
          instr_pc_n    = fetch_pc;
          instr_valid_n = 1'b1;
          fetch_pc_n    = fetch_pc + 1'b1;
          state_n       = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_valid_n = 1'b0;
          state_n       = (instr[15:12] == 4'hF) ? HALT : REQ;
        end
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase

    // Redirect overrides everything above, including discarding a same-cycle memory return.
    if (branch_taken && state != HALT) begin
      fetch_pc_n    = branch_target;
      instr_valid_n = 1'b0;
      instr_n       = instr;
      instr_pc_n    = instr_pc;
      state_n       = REQ;
    end
  end

`ifdef IFETCH_FETCH_CNT_EN
  logic consume;
  assign consume = (state == HOLD) && !stall && !branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (consume && fetch_count != '1)
      fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_W, default 8; SHALL set the program-counter and instruction-memory address width.
REQ-002 Parameter RESET_PC, default 0; SHALL be the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  output  PC_W  SHALL be the instruction-memory word address.
REQ-007 imem_ack  input  1  SHALL indicate imem_rdata is valid for the current request.
REQ-008 imem_rdata  input  16  SHALL carry the returned instruction word.
REQ-009 stall  input  1  SHALL indicate the downstream decoder cannot accept instr this cycle.
REQ-010 branch_taken  input  1  SHALL request a redirect of the fetch PC.
REQ-011 branch_target  input  PC_W  SHALL carry the redirect address.
REQ-012 instr  output  16  SHALL carry the fetched instruction, opcode in bits 15:12.
REQ-013 instr_valid  output  1  SHALL indicate instr holds an unconsumed instruction.
REQ-014 instr_pc  output  PC_W  SHALL carry the address instr was fetched from.
REQ-015 halted  output  1  SHALL indicate a HALT instruction (opcode 4'hF) has been consumed.

Function
REQ-016 FSM SHALL have states IDLE, REQ, HOLD, HALT; imem_req SHALL be 1 only in REQ; imem_addr SHALL always equal fetch_pc.
REQ-017 IDLE SHALL move to REQ on the first rising edge after rst_n deasserts.
REQ-018 REQ with imem_ack=1: instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+1 (mod 2^PC_W), next state HOLD.
REQ-019 REQ with imem_ack=0: all registers hold; imem_req and imem_addr stay stable.
REQ-020 HOLD, stall=1: instr, instr_pc, instr_valid hold.
REQ-021 HOLD, stall=0: instruction consumed at that edge; instr_valid<=0; next state HALT if instr[15:12]==4'hF, else REQ.
REQ-022 HALT: halted=1, imem_req=0, instr_valid=0; exit only via reset.
REQ-023 branch_taken=1 in IDLE, REQ or HOLD: fetch_pc<=branch_target, instr_valid<=0, next state REQ; SHALL take priority over imem_ack, stall and HALT decode.
REQ-024 Branch and imem_ack in the same REQ cycle: imem_rdata SHALL be discarded; instr and instr_pc SHALL not update.
REQ-025 branch_taken SHALL be ignored in HALT.
REQ-026 fetch_pc at all-ones SHALL wrap to 0 after a successful fetch.
REQ-027 Throughput with zero-wait memory and stall=0 SHALL be one instruction per 2 cycles (REQ, HOLD).

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, imem_req=0, instr=16'h0000, instr_valid=0, instr_pc=0, halted=0.
REQ-029 Reset asserted mid-request or in HALT SHALL abandon the request with no further output change until released.

Configuration
REQ-030 Macro IFETCH_FETCH_CNT_EN defined: output fetch_count (16 bit), reset 0, SHALL increment by 1 on each consumed instruction (REQ-021), saturating at 16'hFFFF.
REQ-031 Macro IFETCH_FETCH_CNT_EN undefined: fetch_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, RESET_PC=0, ack every REQ cycle, rdata=16'h0123,16'h1456 -> imem_addr 0 then 1; instr_valid with instr 16'h0123/instr_pc 0, then 16'h1456/instr_pc 1.
REQ-033 Instruction valid in HOLD, stall=1 for 3 cycles -> instr, instr_pc, instr_valid unchanged; imem_req=0; fetch resumes at next address one edge after stall=0.
REQ-034 branch_taken=1, branch_target=8'h40 in the cycle imem_ack=1 rdata=16'h2AAA -> instr not updated, instr_valid=0, next imem_addr=8'h40.
REQ-035 Fetch rdata=16'hF000, stall=0 -> halted=1 next cycle, imem_req stays 0; branch_taken=1 ignored; rst_n pulse -> halted=0, imem_addr=RESET_PC.
REQ-036 RESET_PC=8'hFF, ack immediately -> instr_pc=8'hFF, next imem_addr=8'h00.
REQ-037 With IFETCH_FETCH_CNT_EN: 5 consumed instructions -> fetch_count=5; rst_n=0 asynchronously mid-REQ -> fetch_count=0, imem_req=0 in the same cycle.
